shift_unit_iter: RTL and testbench
==================================

// Module: shift_unit_iter
// PURPOSE
// - Multi-cycle 32-bit shifter for the ALU: SLL and SRA by a 5-bit shamt.
// - Applies one fixed stage per cycle (16, 8, 4, 2, 1), each gated by the matching shamt bit.
// - Holds operands in a local accumulator and reports completion with a busy/done handshake.
// - Sits between operand select and the ALU result mux, replacing the 5-level combinational shifter.
// PARAMETERS
// - WIDTH   32  datapath width; only 32 is supported.
// - STAGES  5   log2(WIDTH); number of shift cycles. Stage weights are 16, 8, 4, 2, 1.
// PORTS
// - clock     in   1   single clock; all state changes on the rising edge
// - reset_n   in   1   synchronous reset, active-low
// - start     in   1   request a shift; sampled only when busy==0
// - op        in   1   0 = SLL, 1 = SRA
// - data_in   in   32  operand A; sampled with start
// - shamt     in   5   shift amount; sampled with start
// - data_out  out  32  result; valid from done and held until the next result
// - busy      out  1   high while a shift is in progress
// - done      out  1   one-cycle pulse when data_out updates
// BEHAVIOUR
// - Reset: reset_n==0 at a clock edge gives state=IDLE, data_out=0, busy=0, done=0,
//   accumulator=0 and stage count=0.
// - Reset mid-operation aborts the operation. No done is produced for it.
// - States and transitions:
//   - IDLE: if start, latch data_in into acc and latch op and shamt; stage=0; go to SHIFT.
//   - SHIFT: at each edge, k=4-stage.
//     - If shamt_r[k]==1, acc is shifted by 2^k: SLL fills with zeros, SRA fills with acc[31].
//     - If shamt_r[k]==0, acc is unchanged.
//     - After the stage==4 edge: data_out <= final acc, done <= 1, go to DONE.
//     - Otherwise stage++.
//   - DONE: done=1 for this cycle only. busy=0, so start is accepted here and handled as in
//     IDLE (back-to-back operation). With no start, go to IDLE.
// - Latency is fixed for every shamt, including 0.
//   - start is sampled at edge E; the shift stages run at edges E+1 to E+5.
//   - done is high in the cycle after edge E+5. One issue every 6 cycles at most.
// - busy is registered: 1 from edge E through edge E+5, otherwise 0.
// - start while busy==1 is ignored. Operands and the result are unaffected.
// - data_in, op and shamt may change freely after being sampled.
// - Arithmetic rules:
//   - SRA sign is taken from the accumulator each stage, which equals the original bit 31.
//   - SLL by 31 keeps only bit 0, which moves to bit 31.
//   - No carry out, no overflow flag.
// - data_out changes only on the done edge or on reset.
// TESTING
// - sra 0x80000000, shamt=16 -> done 6 cycles after start, data_out=0xFFFF8000.
// - sll 0x00000001, shamt=31 -> data_out=0x80000000. sra 0x7FFFFFFF, shamt=31 -> 0x00000000.
// - sra 0xF0000000, shamt=5 -> 0xFF800000. shamt=0 with any A -> data_out=A, latency still 6.
// - start pulses while busy, with different data -> ignored; first result intact and one done only.
// - reset_n low during SHIFT stage 2 -> next cycle data_out=0, busy=0, done=0, no done follows.
// - start asserted in the done cycle (sll 0x3, shamt=4) -> accepted, second done 6 cycles later,
//   data_out=0x30.

Source files
------------

// File: rtl/shift_unit_iter.sv
// Iterative 32-bit SLL/SRA: one power-of-two stage per cycle (16,8,4,2,1), so
// every shift has the same latency. Results come back through a busy/done handshake.
module shift_unit_iter #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              op,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [STAGES-1:0] shamt,
  output logic [WIDTH-1:0]  data_out,
  output logic              busy,
  output logic              done
);
  localparam int SW = $clog2(STAGES);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  data_out_q, data_out_d;
  logic [STAGES-1:0] shamt_q, shamt_d;
  logic [SW-1:0]     stage_q, stage_d;
  logic              op_q, op_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [SW-1:0]     k;
  logic [STAGES-1:0] step;
  logic [WIDTH-1:0]  shifted;

  // Stages run from the heaviest weight down: stage 0 uses shamt bit STAGES-1.
  always_comb begin
    k       = SW'(STAGES - 1) - stage_q;
    step    = STAGES'(1) << k;
    shifted = op_q ? WIDTH'($signed(acc_q) >>> step) : (acc_q << step);
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    data_out_d = data_out_q;
    shamt_d    = shamt_q;
    stage_d    = stage_q;
    op_d       = op_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      SHIFT: begin
        if (shamt_q[k]) acc_d = shifted;
        if (stage_q == SW'(STAGES - 1)) begin
          data_out_d = acc_d;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = DONE;
        end else begin
          stage_d = stage_q + SW'(1);
        end
      end
      default: begin
        // DONE behaves like IDLE so a new request can issue back-to-back.
        if (start) begin
          acc_d   = data_in;
          op_d    = op;
          shamt_d = shamt;
          stage_d = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      data_out_q <= '0;
      shamt_q    <= '0;
      stage_q    <= '0;
      op_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      data_out_q <= data_out_d;
      shamt_q    <= shamt_d;
      stage_q    <= stage_d;
      op_q       <= op_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_shift_unit_iter.sv
// Scoreboard bench for shift_unit_iter: directed corner cases plus random traffic,
// checked against a one-step arithmetic shift model with exact done timing.
module tb_shift_unit_iter;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] data_in = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] data_out;
  logic        busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] last_res = '0;

  typedef struct { logic [31:0] d; int c; } exp_t;
  exp_t sb[$];

  shift_unit_iter dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .data_in(data_in), .shamt(shamt),
    .data_out(data_out), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  initial begin
    #400000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] model(input logic o, input logic [31:0] a, input logic [4:0] s);
    if (o) return 32'($signed(a) >>> s);
    return a << s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops on every done, and checks data_out holds between results.
  always @(negedge clock) begin
    if (!reset_n) begin
      last_res = '0;
    end else if (done) begin
      exp_t e;
      if (sb.size() == 0) begin
        chk("unexpected_done", data_out, last_res);
        checks++; errors++;
        $display("FAIL spurious_done got=1 want=0 cyc=%0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("result", data_out, e.d);
        chk("latency", 32'(cyc), 32'(e.c));
        last_res = e.d;
      end
    end else begin
      chk("hold", data_out, last_res);
    end
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic issue(input logic o, input logic [31:0] a, input logic [4:0] s);
    int g = 0;
    while (busy && g < 50) begin @(negedge clock); g++; end
    if (busy) begin checks++; errors++; $display("FAIL wait_not_busy got=1 want=0"); end
    start = 1'b1; op = o; data_in = a; shamt = s;
    sb.push_back('{model(o, a, s), cyc + 6});
    @(negedge clock);
    start = 1'b0; op = 1'($urandom); data_in = $urandom; shamt = 5'($urandom);
  endtask

  task automatic drain();
    int g = 0;
    while ((sb.size() != 0 || busy) && g < 100) begin @(negedge clock); g++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout got=%0d want=0 pending", sb.size());
    end
    @(negedge clock);
  endtask

  task automatic wait_done();
    int g = 0;
    while (!done && g < 20) begin @(negedge clock); g++; end
    if (!done) begin checks++; errors++; $display("FAIL wait_done got=0 want=1"); end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed corner cases
    issue(1'b1, 32'h8000_0000, 5'd16);
    chk("busy_after_start", 32'(busy), 32'h1);
    drain();
    issue(1'b0, 32'h0000_0001, 5'd31); drain();
    chk("sll31", data_out, 32'h8000_0000);
    issue(1'b1, 32'h7FFF_FFFF, 5'd31); drain();
    chk("sra31_pos", data_out, 32'h0);
    issue(1'b1, 32'hF000_0000, 5'd5);  drain();
    chk("sra5_neg", data_out, 32'hFF80_0000);
    issue(1'b0, 32'hDEAD_BEEF, 5'd0);  drain();
    chk("shamt0", data_out, 32'hDEAD_BEEF);

    // Starts while busy must be ignored
    issue(1'b0, 32'h0000_00F0, 5'd4);
    repeat (4) begin
      start = 1'b1; op = 1'b1; data_in = $urandom; shamt = 5'($urandom);
      @(negedge clock);
    end
    start = 1'b0;
    drain();
    chk("ignored_starts", data_out, 32'h0000_0F00);

    // Back-to-back issue in the done cycle
    issue(1'b1, 32'h8765_4321, 5'd8);
    wait_done();
    issue(1'b0, 32'h0000_0003, 5'd4);
    chk("busy_b2b", 32'(busy), 32'h1);
    drain();
    chk("b2b_result", data_out, 32'h0000_0030);

    // Reset during shift stage 2 aborts with no done
    issue(1'b1, 32'h1234_5678, 5'd7);
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("abort_data_out", data_out, 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    void'(sb.pop_back());
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    chk("abort_idle_busy", 32'(busy), 32'h0);

    // Random traffic, mixing gaps and immediate re-issue
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = a | 32'h8000_0000;
      issue(1'($urandom), a, 5'($urandom));
      if ($urandom_range(0, 1) == 1) wait_done();
      else repeat ($urandom_range(0, 8)) @(negedge clock);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
